alu_req_arbiter: RTL and testbench
==================================

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one ALU (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, ALU operand/result width.
REQ-003 SHALL have parameter ALU_LAT, default 1, alu_clk cycles from issue to valid alu_out (1..4).
REQ-004 SHALL have a single clock: alu_clk  in  1  rising-edge clock for all state.
REQ-005 SHALL have reset rst_n  in  1, asynchronous, active-low.
REQ-006 SHALL have req_valid  in  NUM_REQ  per-requester operation request.
REQ-007 SHALL have req_ready  out  NUM_REQ  one-hot grant; a transfer occurs on valid&ready.
REQ-008 SHALL have req_mode  in  NUM_REQ  per-requester ALU half select: 0 = A-set, 1 = B-set.
REQ-009 SHALL have req_op  in  NUM_REQ*2  per-requester 2-bit opcode.
REQ-010 SHALL have req_a / req_b  in  NUM_REQ*DATA_W each  per-requester operands.
REQ-011 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_id out $clog2(NUM_REQ), rsp_data out DATA_W, rsp_irq out 1.
REQ-012 SHALL have ALU-side outputs alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr (1 each), alu_op_a, alu_op_b (2 each), alu_in_a, alu_in_b (DATA_W each).
REQ-013 SHALL have ALU-side inputs alu_out (DATA_W) and alu_irq (1).
REQ-014 SHALL have op_count  out  16  count of completed responses, wraps 16'hFFFF -> 0.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, IRQ_CLR.
REQ-016 IDLE: if any req_valid, SHALL assert req_ready for exactly one winner in the same cycle, latch its mode/op/a/b/id, go to ISSUE; otherwise stay.
REQ-017 Arbitration SHALL be round-robin: search starts at index last_grant+1 mod NUM_REQ; pointer is 0 after reset (requester 0 is highest priority first).
REQ-018 req_ready SHALL be 0 in every state except IDLE.
REQ-019 ISSUE (1 cycle): SHALL drive alu_enable=1, alu_enable_a=~mode, alu_enable_b=mode, latched op on alu_op_a (mode 0) or alu_op_b (mode 1), operands on alu_in_a/alu_in_b; load latency counter with ALU_LAT-1; go to WAIT.
REQ-020 In all states other than ISSUE, alu_enable/alu_enable_a/alu_enable_b SHALL be 0; alu_op_*/alu_in_* hold their last values.
REQ-021 WAIT: counter decrements each cycle; when 0, SHALL sample alu_out into rsp_data and alu_irq into rsp_irq, go to RESP.
REQ-022 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_irq stable until rsp_ready; on rsp_valid&rsp_ready, op_count increments, next state is IRQ_CLR if rsp_irq else IDLE.
REQ-023 IRQ_CLR: alu_irq_clr=1 for exactly one cycle, then IDLE.
REQ-024 Request-to-response minimum latency SHALL be 2+ALU_LAT cycles (grant edge to rsp_valid).
REQ-025 req_valid deasserted before grant SHALL be ignored; no request is lost or duplicated.
REQ-026 New grants SHALL not occur until the prior response handshakes and any IRQ_CLR completes (one transaction in flight).

Reset
REQ-027 On rst_n low, SHALL go to IDLE, clear grant pointer, counter, op_count, and drive all outputs to 0 immediately, independent of alu_clk.
REQ-028 Reset mid-transaction SHALL drop it: no rsp_valid, no alu_irq_clr after release.

Structure
REQ-029 Package alu_ctrl_pkg SHALL hold the FSM state enum, mode enum (MODE_A, MODE_B), and DATA_W/opcode width constants.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out).

Verification
REQ-031 Single request: req 2, mode 0, op 2'b01, a=8'h12, b=8'h34, ALU_LAT=1, alu_out=8'h5A -> alu_enable&alu_enable_a one cycle, rsp_id=2, rsp_data=8'h5A, rsp_valid 3 cycles after grant.
REQ-032 All four requesters valid continuously -> grants in order 0,1,2,3,0; op_count=5 after five responses.
REQ-033 alu_irq=1 at sample, rsp_irq=1 -> after handshake, alu_irq_clr high exactly one cycle, then next grant.
REQ-034 rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, req_ready all 0 throughout.
REQ-035 rst_n pulsed low during WAIT -> all outputs 0 asynchronously, pointer reset, no response emitted; next grant goes to requester 0.
REQ-036 op_count preloaded to 16'hFFFF via 65535 transactions -> next response wraps it to 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU request arbiter: FSM states,
// ALU half select, operand/opcode widths and the round-robin wrap helper.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W       = 2;
  localparam int LAT_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RESP    = 3'd3,
    ST_IRQ_CLR = 3'd4
  } state_e;

  typedef enum logic {
    MODE_A = 1'b0,
    MODE_B = 1'b1
  } mode_e;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first asserted request at or after the
// start pointer, returning a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_any && i_req[w_k]) begin
        o_grant[w_k] = 1'b1;
        o_idx        = w_k;
        o_any        = 1'b1;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one two-half ALU among NUM_REQ requesters, one transaction in flight:
// round-robin grant, issue, fixed-latency wait, response handshake, irq clear.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ALU_LAT = 1,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      alu_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_mode,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_irq,
  output logic                      alu_enable,
  output logic                      alu_enable_a,
  output logic                      alu_enable_b,
  output logic                      alu_irq_clr,
  output logic [OP_W-1:0]           alu_op_a,
  output logic [OP_W-1:0]           alu_op_b,
  output logic [DATA_W-1:0]         alu_in_a,
  output logic [DATA_W-1:0]         alu_in_b,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_irq,
  output logic [15:0]               op_count
);

  state_e              r_state;
  state_e              w_next_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  mode_e               r_mode;
  logic [OP_W-1:0]     r_alu_op_a;
  logic [OP_W-1:0]     r_alu_op_b;
  logic [DATA_W-1:0]   r_alu_in_a;
  logic [DATA_W-1:0]   r_alu_in_b;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_irq;
  logic [15:0]         r_op_count;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_idx;
  logic                w_any;
  logic                w_take;
  logic                w_sel_mode;
  logic [OP_W-1:0]     w_sel_op;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic                w_alu_enable;
  logic                w_alu_enable_a;
  logic                w_alu_enable_b;
  logic                w_rsp_valid;
  logic                w_irq_clr;
  logic                w_rsp_fire;
  logic                w_lat_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_take     = (r_state == ST_IDLE) && w_any;
  assign w_sel_mode = req_mode[w_idx];
  assign w_sel_op   = req_op[w_idx*OP_W +: OP_W];
  assign w_sel_a    = req_a[w_idx*DATA_W +: DATA_W];
  assign w_sel_b    = req_b[w_idx*DATA_W +: DATA_W];
  assign w_lat_done = (r_state == ST_WAIT) && (r_lat_cnt == '0);
  assign w_rsp_fire = w_rsp_valid && rsp_ready;

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next_state = ST_ISSUE;
        else       w_next_state = ST_IDLE;
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (r_lat_cnt == '0) w_next_state = ST_RESP;
        else                 w_next_state = ST_WAIT;
      end
      ST_RESP: begin
        if (rsp_ready) w_next_state = r_rsp_irq ? ST_IRQ_CLR : ST_IDLE;
        else           w_next_state = ST_RESP;
      end
      ST_IRQ_CLR: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready    = '0;
    w_alu_enable   = 1'b0;
    w_alu_enable_a = 1'b0;
    w_alu_enable_b = 1'b0;
    w_rsp_valid    = 1'b0;
    w_irq_clr      = 1'b0;
    case (r_state)
      ST_IDLE: w_req_ready = w_grant;
      ST_ISSUE: begin
        w_alu_enable   = 1'b1;
        w_alu_enable_a = (r_mode == MODE_A);
        w_alu_enable_b = (r_mode == MODE_B);
      end
      ST_RESP:    w_rsp_valid = 1'b1;
      ST_IRQ_CLR: w_irq_clr   = 1'b1;
      default:    w_req_ready = '0;
    endcase
  end

  // Grant capture: requester id, operands, opcode into the selected half.
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_mode     <= MODE_A;
      r_alu_op_a <= '0;
      r_alu_op_b <= '0;
      r_alu_in_a <= '0;
      r_alu_in_b <= '0;
    end else if (w_take) begin
      r_ptr      <= ID_W'(rr_next(int'(w_idx), NUM_REQ));
      r_id       <= w_idx;
      r_mode     <= mode_e'(w_sel_mode);
      r_alu_in_a <= w_sel_a;
      r_alu_in_b <= w_sel_b;
      if (w_sel_mode == MODE_B) r_alu_op_b <= w_sel_op;
      else                      r_alu_op_a <= w_sel_op;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_lat_cnt <= LAT_W'(ALU_LAT - 1);
    end else if ((r_state == ST_WAIT) && (r_lat_cnt != '0)) begin
      r_lat_cnt <= r_lat_cnt - LAT_W'(1);
    end else begin
      r_lat_cnt <= r_lat_cnt;
    end
  end

  // Response capture on the last wait cycle and completed-op counting.
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_irq  <= 1'b0;
      r_op_count <= 16'd0;
    end else begin
      if (w_lat_done) begin
        r_rsp_data <= alu_out;
        r_rsp_irq  <= alu_irq;
      end else begin
        r_rsp_data <= r_rsp_data;
      end
      if (w_rsp_fire) r_op_count <= r_op_count + 16'd1;
      else            r_op_count <= r_op_count;
    end
  end

  // Grant is combinational from req_valid, so it must be masked during reset.
  assign req_ready    = rst_n ? w_req_ready : '0;
  assign alu_enable   = w_alu_enable;
  assign alu_enable_a = w_alu_enable_a;
  assign alu_enable_b = w_alu_enable_b;
  assign alu_irq_clr  = w_irq_clr;
  assign alu_op_a     = r_alu_op_a;
  assign alu_op_b     = r_alu_op_b;
  assign alu_in_a     = r_alu_in_a;
  assign alu_in_b     = r_alu_in_b;
  assign rsp_valid    = w_rsp_valid;
  assign rsp_id       = r_id;
  assign rsp_data     = r_rsp_data;
  assign rsp_irq      = r_rsp_irq;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter (NUM_REQ=4, DATA_W=8, ALU_LAT=1).
module tb_alu_req_arbiter;

  logic        alu_clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_mode;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_irq;
  logic        alu_enable;
  logic        alu_enable_a;
  logic        alu_enable_b;
  logic        alu_irq_clr;
  logic [1:0]  alu_op_a;
  logic [1:0]  alu_op_b;
  logic [7:0]  alu_in_a;
  logic [7:0]  alu_in_b;
  logic [7:0]  alu_out;
  logic        alu_irq;
  logic [15:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  alu_req_arbiter #(.NUM_REQ(4), .DATA_W(8), .ALU_LAT(1)) dut (
    .alu_clk      (alu_clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mode     (req_mode),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_irq      (rsp_irq),
    .alu_enable   (alu_enable),
    .alu_enable_a (alu_enable_a),
    .alu_enable_b (alu_enable_b),
    .alu_irq_clr  (alu_irq_clr),
    .alu_op_a     (alu_op_a),
    .alu_op_b     (alu_op_b),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_out      (alu_out),
    .alu_irq      (alu_irq),
    .op_count     (op_count)
  );

  initial alu_clk = 1'b0;
  always #5 alu_clk = ~alu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_mode  = 4'b0000;
    req_op    = 8'h00;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b0;
    alu_out   = 8'h00;
    alu_irq   = 1'b0;

    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 32'h0);
    chk("rst_alu_enable", alu_enable, 32'h0);
    chk("rst_irq_clr", alu_irq_clr, 32'h0);
    chk("rst_op_count", op_count, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    req_valid = 4'b0000;
    @(negedge alu_clk);
    rst_n = 1'b1;

    // Single request from requester 2, mode A
    @(negedge alu_clk);
    req_valid = 4'b0100;
    req_mode  = 4'b0000;
    req_op    = 8'b00_01_00_00;
    req_a     = 32'h0012_0000;
    req_b     = 32'h0034_0000;
    alu_out   = 8'h5A;
    #1 chk("t1_grant", req_ready, 32'h4);
    @(negedge alu_clk);
    req_valid = 4'b0000;
    chk("t1_issue_en", alu_enable, 32'h1);
    chk("t1_issue_en_a", alu_enable_a, 32'h1);
    chk("t1_issue_en_b", alu_enable_b, 32'h0);
    chk("t1_op_a", alu_op_a, 32'h1);
    chk("t1_in_a", alu_in_a, 32'h12);
    chk("t1_in_b", alu_in_b, 32'h34);
    chk("t1_issue_rsp_valid", rsp_valid, 32'h0);
    @(negedge alu_clk);
    chk("t1_wait_en", alu_enable, 32'h0);
    chk("t1_wait_rsp_valid", rsp_valid, 32'h0);
    @(negedge alu_clk);
    chk("t1_rsp_valid", rsp_valid, 32'h1);
    chk("t1_rsp_id", rsp_id, 32'h2);
    chk("t1_rsp_data", rsp_data, 32'h5A);
    chk("t1_rsp_irq", rsp_irq, 32'h0);

    // Back-pressure: response held, no grants while others request
    req_valid = 4'b1011;
    alu_out   = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      @(negedge alu_clk);
      chk("bp_rsp_valid", rsp_valid, 32'h1);
      chk("bp_rsp_data", rsp_data, 32'h5A);
      chk("bp_req_ready", req_ready, 32'h0);
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    @(negedge alu_clk);
    rsp_ready = 1'b0;
    chk("t1_done_rsp_valid", rsp_valid, 32'h0);
    chk("t1_done_op_count", op_count, 32'h1);
    chk("t1_done_irq_clr", alu_irq_clr, 32'h0);

    // IRQ response from requester 1, mode B
    req_valid = 4'b0010;
    req_mode  = 4'b0010;
    req_op    = 8'b00_00_10_00;
    req_a     = 32'h0000_AA00;
    req_b     = 32'h0000_5500;
    alu_out   = 8'hC3;
    alu_irq   = 1'b1;
    #1 chk("t2_grant", req_ready, 32'h2);
    @(negedge alu_clk);
    req_valid = 4'b0000;
    chk("t2_en_a", alu_enable_a, 32'h0);
    chk("t2_en_b", alu_enable_b, 32'h1);
    chk("t2_op_b", alu_op_b, 32'h2);
    chk("t2_op_a_hold", alu_op_a, 32'h1);
    chk("t2_in_a", alu_in_a, 32'hAA);
    chk("t2_in_b", alu_in_b, 32'h55);
    @(negedge alu_clk);
    @(negedge alu_clk);
    chk("t2_rsp_irq", rsp_irq, 32'h1);
    chk("t2_rsp_id", rsp_id, 32'h1);
    chk("t2_rsp_data", rsp_data, 32'hC3);
    rsp_ready = 1'b1;
    alu_irq   = 1'b0;
    req_valid = 4'b1001;
    @(negedge alu_clk);
    rsp_ready = 1'b0;
    chk("t2_irq_clr_hi", alu_irq_clr, 32'h1);
    chk("t2_irq_clr_ready", req_ready, 32'h0);
    chk("t2_irq_clr_rsp_valid", rsp_valid, 32'h0);
    @(negedge alu_clk);
    chk("t2_irq_clr_lo", alu_irq_clr, 32'h0);
    chk("t2_rr_next", req_ready, 32'h8);

    // Request withdrawn before grant edge is ignored
    req_valid = 4'b0000;
    #1 chk("wd_ready", req_ready, 32'h0);
    @(negedge alu_clk);
    chk("wd_no_issue", alu_enable, 32'h0);

    // Reset during WAIT drops the transaction
    req_valid = 4'b1001;
    #1 chk("t3_grant", req_ready, 32'h8);
    @(negedge alu_clk);
    req_valid = 4'b0000;
    chk("t3_issue", alu_enable, 32'h1);
    @(negedge alu_clk);
    req_valid = 4'b1001;
    rst_n     = 1'b0;
    #1;
    chk("t3_rst_en", alu_enable, 32'h0);
    chk("t3_rst_rsp_valid", rsp_valid, 32'h0);
    chk("t3_rst_op_count", op_count, 32'h0);
    chk("t3_rst_in_a", alu_in_a, 32'h0);
    chk("t3_rst_op_a", alu_op_a, 32'h0);
    chk("t3_rst_rsp_id", rsp_id, 32'h0);
    chk("t3_rst_ready", req_ready, 32'h0);
    @(negedge alu_clk);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    req_mode  = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    chk("t3_post_rsp_valid", rsp_valid, 32'h0);
    chk("t3_post_irq_clr", alu_irq_clr, 32'h0);

    // All requesters continuously valid: 0,1,2,3,0
    for (int t = 0; t < 5; t++) begin
      alu_out = 8'h10 + 8'(t);
      #1 chk("rr_grant", req_ready, 32'(1 << (t % 4)));
      @(negedge alu_clk);
      chk("rr_issue", alu_enable, 32'h1);
      @(negedge alu_clk);
      @(negedge alu_clk);
      chk("rr_rsp_valid", rsp_valid, 32'h1);
      chk("rr_rsp_id", rsp_id, 32'(t % 4));
      chk("rr_rsp_data", rsp_data, 32'h10 + 32'(t));
      @(negedge alu_clk);
    end
    req_valid = 4'b0000;
    chk("rr_op_count", op_count, 32'h5);

    // op_count wrap from 16'hFFFF
    force dut.r_op_count = 16'hFFFF;
    #1 release dut.r_op_count;
    #1 chk("wrap_preload", op_count, 32'hFFFF);
    req_valid = 4'b0100;
    alu_out   = 8'h77;
    #1 chk("wrap_grant", req_ready, 32'h4);
    @(negedge alu_clk);
    req_valid = 4'b0000;
    @(negedge alu_clk);
    @(negedge alu_clk);
    chk("wrap_rsp_valid", rsp_valid, 32'h1);
    chk("wrap_rsp_data", rsp_data, 32'h77);
    chk("wrap_before", op_count, 32'hFFFF);
    @(negedge alu_clk);
    chk("wrap_after", op_count, 32'h0);
    chk("wrap_rsp_done", rsp_valid, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
